serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor; computes D = A - B, LSB first, one bit per clock.
- Each bit uses a single full-subtractor cell plus a borrow flip-flop. This is the subtract-direction counterpart of the team's full-adder cells.
- Sits in the datapath library as a low-area arithmetic unit. A start/busy/done handshake sequences it.

---
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first, start/busy/done sequenced
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bo_q, bo_d;
    logic             ovf_q, ovf_d;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    logic             ai, bi, di, br_next;
    logic [WIDTH-1:0] sd_next;

    assign ai      = sa_q[0];
    assign bi      = sb_q[0];
    assign di      = ai ^ bi ^ br_q;
    assign br_next = (~ai & bi) | (~(ai ^ bi) & br_q);
    assign sd_next = {di, sd_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bo_d    = bo_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                sd_d  = sd_next;
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                // The last bit's difference is the result MSB, so overflow uses di directly.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    d_d     = sd_next;
                    bo_d    = br_next;
                    ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ di);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);
    assign d    = d_q;
    assign bo   = bo_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bo;
    logic         ovf;

    int n_checks;
    int n_errors;

    // Last completed result the outputs must be holding.
    logic [W-1:0] exp_d;
    logic         exp_bo;
    logic         exp_ovf;

    // Reference result for the operation in flight.
    logic [W-1:0] m_d;
    logic         m_bo;
    logic         m_ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib);
        int diff;
        int sdiff;
        diff  = int'(ia) - int'(ib);
        sdiff = int'($signed(ia)) - int'($signed(ib));
        m_d   = W'(diff);
        m_bo  = (diff < 0);
        m_ovf = (sdiff > 127) || (sdiff < -128);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, d, bo, ovf} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: busy=%b done=%b d=%h bo=%b ovf=%b, required all zero", busy, done, d, bo, ovf);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        exp_d   = '0;
        exp_bo  = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit scramble);
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model(ia, ib);
        for (int i = 0; i < W; i++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_phase[%0d]: busy=%b done=%b, required 1 0", i, busy, done);
            end
            n_checks++;
            if (d !== exp_d || bo !== exp_bo || ovf !== exp_ovf) begin
                n_errors++;
                $display("FAIL hold_result[%0d]: d=%h bo=%b ovf=%b, required %h %b %b", i, d, bo, ovf, exp_d, exp_bo, exp_ovf);
            end
            if (scramble) begin
                a     = W'($urandom);
                b     = W'($urandom);
                start = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL done_pulse: done=%b busy=%b, required 1 0", done, busy);
        end
        n_checks++;
        if (d !== m_d || bo !== m_bo || ovf !== m_ovf) begin
            n_errors++;
            $display("FAIL result %h-%h: d=%h bo=%b ovf=%b, required %h %b %b", ia, ib, d, bo, ovf, m_d, m_bo, m_ovf);
        end
        exp_d   = m_d;
        exp_bo  = m_bo;
        exp_ovf = m_ovf;
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [7];
        logic [W-1:0] tb [7];
        ta = '{8'h35, 8'h00, 8'h80, 8'h00, 8'hA5, 8'hFF, 8'h7F};
        tb = '{8'h12, 8'h01, 8'h01, 8'hFF, 8'hA5, 8'h00, 8'h80};
        for (int i = 0; i < 7; i++) do_op(ta[i], tb[i], 1'b0);
    endtask

    task automatic test_capture();
        do_op(8'hC3, 8'h4E, 1'b1);
        do_op(8'h01, 8'h02, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ca;
        logic [W-1:0] cb;
        int phase;
        ca = 8'h9C;
        cb = 8'h27;
        @(negedge clk);
        a     = ca;
        b     = cb;
        start = 1'b1;
        @(posedge clk);
        #1;
        // Each held-start operation is W busy cycles, one done cycle, one idle cycle.
        for (int c = 0; c < 30; c++) begin
            phase = c % (W + 2);
            n_checks++;
            if (busy !== (phase < W) || done !== (phase == W)) begin
                n_errors++;
                $display("FAIL b2b_timing[%0d]: busy=%b done=%b, required %b %b", c, busy, done, phase < W, phase == W);
            end
            if (phase < W) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            if (phase == W) begin
                model(ca, cb);
                n_checks++;
                if (d !== m_d || bo !== m_bo || ovf !== m_ovf) begin
                    n_errors++;
                    $display("FAIL b2b_result %h-%h: d=%h bo=%b ovf=%b, required %h %b %b", ca, cb, d, bo, ovf, m_d, m_bo, m_ovf);
                end
                exp_d   = m_d;
                exp_bo  = m_bo;
                exp_ovf = m_ovf;
            end
            if (phase == W + 1) begin
                if (c == 29) begin
                    start = 1'b0;
                end else begin
                    ca = W'($urandom);
                    cb = W'($urandom);
                    a  = ca;
                    b  = cb;
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        a     = 8'h5A;
        b     = 8'h13;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, d, bo, ovf} !== '0) begin
            n_errors++;
            $display("FAIL async_abort: busy=%b done=%b d=%h bo=%b ovf=%b, required all zero", busy, done, d, bo, ovf);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) rst_n = 1'b1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL abort_no_done[%0d]: done=%b busy=%b, required 0 0", i, done, busy);
            end
        end
        exp_d   = '0;
        exp_bo  = 1'b0;
        exp_ovf = 1'b0;
        do_op(8'h10, 8'h03, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) do_op(W'($urandom), W'($urandom), ($urandom_range(0, 1) == 1));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_directed();
        test_capture();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
